// File: rtl/reg_write_scoreboard.sv
// Register-pending scoreboard: one saturating-free counter per architectural register,
// bumped on issue, dropped on writeback, queried by the two decode-stage sources.
module reg_write_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter bit ZERO_EN  = 1'b1,
  parameter int ZERO_REG = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_rd,
  output logic                   issue_ready,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_rd,
  input  logic [ADDR_W-1:0]      rs_a,
  input  logic [ADDR_W-1:0]      rs_b,
  output logic                   busy_a,
  output logic                   busy_b,
  output logic [2**ADDR_W-1:0]   pending_vec,
  output logic                   wb_underflow
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0]   ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [CNT_W-1:0]    cnt_issue;
  logic [CNT_W-1:0]    cnt_wb;
  logic                issue_zero;
  logic                wb_zero;
  logic                issue_acc;
  logic                wb_act;
  logic                underflow_now;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // Issue handshake: an issue transfers on a rising edge when issue_en && issue_ready;
  // issue_ready never depends on issue_en, and a same-cycle retire to that register frees a slot.
  always_comb begin
    cnt_issue     = cnt[issue_rd];
    cnt_wb        = cnt[wb_rd];
    issue_zero    = ZERO_EN && (issue_rd == ZERO_IDX);
    wb_zero       = ZERO_EN && (wb_rd == ZERO_IDX);
    issue_ready   = issue_zero || (cnt_issue != '1) ||
                    (wb_en && (wb_rd == issue_rd) && (cnt_issue != '0));
    issue_acc     = issue_en && issue_ready && !issue_zero;
    wb_act        = wb_en && !wb_zero;
    underflow_now = wb_act && (cnt_wb == '0);
    inc_vec       = issue_acc ? (ONE_HOT0 << issue_rd) : '0;
    // An underflowing writeback never decrements, so a paired issue still lands as +1.
    dec_vec       = (wb_act && !underflow_now) ? (ONE_HOT0 << wb_rd) : '0;
  end

  always_comb begin
    pending_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_vec[i] = (cnt[i] != '0) && !(ZERO_EN && (i == ZERO_REG));
    end
    busy_a = pending_vec[rs_a];
    busy_b = pending_vec[rs_b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      wb_underflow <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
      if (underflow_now) wb_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench: a vector table for the default 32-register scoreboard, then a short
// hand sequence on an 8-register instance with zero-register masking disabled.
module tb_reg_write_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance (ADDR_W=5, ZERO_EN=1, ZERO_REG=31)
  logic        reset, flush, issue_en, wb_en;
  logic [4:0]  issue_rd, wb_rd, rs_a, rs_b;
  logic        issue_ready, busy_a, busy_b, wb_underflow;
  logic [31:0] pending_vec;

  reg_write_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .rs_a(rs_a), .rs_b(rs_b),
    .busy_a(busy_a), .busy_b(busy_b), .pending_vec(pending_vec),
    .wb_underflow(wb_underflow)
  );

  // small instance (ADDR_W=3, ZERO_EN=0)
  logic       s_reset, s_flush, s_issue_en, s_wb_en;
  logic [2:0] s_issue_rd, s_wb_rd, s_rs_a, s_rs_b;
  logic       s_issue_ready, s_busy_a, s_busy_b, s_wb_underflow;
  logic [7:0] s_pending_vec;

  reg_write_scoreboard #(.ADDR_W(3), .CNT_W(2), .ZERO_EN(1'b0), .ZERO_REG(31)) dut_small (
    .clk(clk), .reset(s_reset), .flush(s_flush),
    .issue_en(s_issue_en), .issue_rd(s_issue_rd), .issue_ready(s_issue_ready),
    .wb_en(s_wb_en), .wb_rd(s_wb_rd), .rs_a(s_rs_a), .rs_b(s_rs_b),
    .busy_a(s_busy_a), .busy_b(s_busy_b), .pending_vec(s_pending_vec),
    .wb_underflow(s_wb_underflow)
  );

  typedef struct {
    string       name;
    logic        reset, flush, issue_en;
    logic [4:0]  issue_rd;
    logic        wb_en;
    logic [4:0]  wb_rd, rs_a, rs_b;
    logic        exp_rdy, exp_ba, exp_bb, exp_uf;
    logic [31:0] exp_pv;
  } vec_t;

  vec_t vecs[$];
  logic [11:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(string name, logic rst, logic fl, logic ie, logic [4:0] ird,
                              logic we, logic [4:0] wrd, logic [4:0] ra, logic [4:0] rb,
                              logic rdy, logic ba, logic bb, logic uf, logic [31:0] pv);
    vec_t v;
    v.name = name; v.reset = rst; v.flush = fl; v.issue_en = ie; v.issue_rd = ird;
    v.wb_en = we; v.wb_rd = wrd; v.rs_a = ra; v.rs_b = rb;
    v.exp_rdy = rdy; v.exp_ba = ba; v.exp_bb = bb; v.exp_uf = uf; v.exp_pv = pv;
    return v;
  endfunction

  task automatic check(string name, logic [35:0] act, logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got rdy/ba/bb/uf=%b pv=%h, want rdy/ba/bb/uf=%b pv=%h",
               name, act[35:32], act[31:0], exp[35:32], exp[31:0]);
    end
  endtask

  task automatic drive_small(logic ie, logic [2:0] ird, logic we, logic [2:0] wrd, logic [2:0] ra);
    s_reset = 1'b0; s_flush = 1'b0;
    s_issue_en = ie; s_issue_rd = ird; s_wb_en = we; s_wb_rd = wrd; s_rs_a = ra; s_rs_b = 3'd0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_en = 1'b0; issue_rd = '0;
    wb_en = 1'b0; wb_rd = '0; rs_a = '0; rs_b = '0;
    s_reset = 1'b1; s_flush = 1'b0; s_issue_en = 1'b0; s_issue_rd = '0;
    s_wb_en = 1'b0; s_wb_rd = '0; s_rs_a = '0; s_rs_b = '0;

    // Each row: inputs held for one cycle; expected outputs are sampled before that
    // cycle's edge, so they reflect state from earlier rows plus the current inputs.
    //               name           rst fl ie ird we wrd ra  rb   rdy ba bb uf pv
    vecs.push_back(mk("reset_state", 0, 0, 0, 0,  0, 0,  0,  0,   1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("issue3",      0, 0, 1, 3,  0, 0,  3,  0,   1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("busy3",       0, 0, 0, 0,  0, 0,  3,  0,   1, 1, 0, 0, 32'h8));
    vecs.push_back(mk("wb3_nobypass",0, 0, 0, 0,  1, 3,  3,  0,   1, 1, 0, 0, 32'h8));
    vecs.push_back(mk("retired3",    0, 0, 0, 0,  0, 0,  3,  0,   1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("issue7_a",    0, 0, 1, 7,  0, 0,  7,  0,   1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("issue7_b",    0, 0, 1, 7,  0, 0,  7,  0,   1, 1, 0, 0, 32'h80));
    vecs.push_back(mk("issue7_c",    0, 0, 1, 7,  0, 0,  7,  0,   1, 1, 0, 0, 32'h80));
    vecs.push_back(mk("issue7_sat",  0, 0, 1, 7,  0, 0,  7,  0,   0, 1, 0, 0, 32'h80));
    vecs.push_back(mk("issue7_wb7",  0, 0, 1, 7,  1, 7,  7,  0,   1, 1, 0, 0, 32'h80));
    vecs.push_back(mk("still_sat",   0, 0, 1, 7,  0, 0,  7,  0,   0, 1, 0, 0, 32'h80));
    vecs.push_back(mk("wb7_1",       0, 0, 0, 7,  1, 7,  7,  0,   1, 1, 0, 0, 32'h80));
    vecs.push_back(mk("wb7_2",       0, 0, 0, 7,  1, 7,  7,  0,   1, 1, 0, 0, 32'h80));
    vecs.push_back(mk("wb7_3",       0, 0, 0, 7,  1, 7,  7,  0,   1, 1, 0, 0, 32'h80));
    vecs.push_back(mk("drained7",    0, 0, 0, 7,  0, 0,  7,  0,   1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("issue_xzr",   0, 0, 1, 31, 0, 0,  0,  31,  1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("wb_xzr",      0, 0, 0, 0,  1, 31, 0,  31,  1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("xzr_no_uf",   0, 0, 0, 0,  0, 0,  0,  31,  1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("issue5",      0, 0, 1, 5,  0, 0,  0,  0,   1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("issue9",      0, 0, 1, 9,  0, 0,  0,  0,   1, 0, 0, 0, 32'h20));
    vecs.push_back(mk("wb12_uf",     0, 0, 0, 0,  1, 12, 5,  9,   1, 1, 1, 0, 32'h220));
    vecs.push_back(mk("uf_set",      0, 0, 0, 0,  0, 0,  5,  9,   1, 1, 1, 1, 32'h220));
    vecs.push_back(mk("flush_iss2",  0, 1, 1, 2,  1, 5,  5,  9,   1, 1, 1, 1, 32'h220));
    vecs.push_back(mk("post_flush",  0, 0, 0, 2,  0, 0,  5,  2,   1, 0, 0, 1, 32'h0));
    vecs.push_back(mk("reset_iss2",  1, 0, 1, 2,  0, 0,  2,  0,   1, 0, 0, 1, 32'h0));
    vecs.push_back(mk("post_reset",  0, 0, 0, 2,  0, 0,  2,  0,   1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("iss4_wb4_uf", 0, 0, 1, 4,  1, 4,  4,  0,   1, 0, 0, 0, 32'h0));
    vecs.push_back(mk("uf_cnt4_one", 0, 0, 0, 0,  0, 0,  4,  0,   1, 1, 0, 1, 32'h10));
    vecs.push_back(mk("cnt4_wb_ok",  0, 0, 0, 0,  1, 4,  4,  0,   1, 1, 0, 1, 32'h10));
    vecs.push_back(mk("cnt4_empty",  0, 0, 0, 0,  0, 0,  4,  0,   1, 0, 0, 1, 32'h0));

    repeat (2) @(posedge clk);
    #1;
    s_reset = 1'b0;

    foreach (vecs[k]) begin
      reset = vecs[k].reset; flush = vecs[k].flush;
      issue_en = vecs[k].issue_en; issue_rd = vecs[k].issue_rd;
      wb_en = vecs[k].wb_en; wb_rd = vecs[k].wb_rd;
      rs_a = vecs[k].rs_a; rs_b = vecs[k].rs_b;
      @(negedge clk);
      check(vecs[k].name,
            {issue_ready, busy_a, busy_b, wb_underflow, pending_vec},
            {vecs[k].exp_rdy, vecs[k].exp_ba, vecs[k].exp_bb, vecs[k].exp_uf, vecs[k].exp_pv});
      @(posedge clk);
      #1;
    end
    reset = 1'b0; flush = 1'b0; issue_en = 1'b0; wb_en = 1'b0;

    // Small instance: register 7 is an ordinary register when masking is off.
    // Expected word: {issue_ready, busy_a, busy_b, wb_underflow, pending_vec[7:0]}.
    exp_q.push_back({4'b1000, 8'h00});  // issue 3, before edge
    exp_q.push_back({4'b1100, 8'h08});  // wb 3, busy_a on rs_a=3
    exp_q.push_back({4'b1000, 8'h00});  // issue 7, rs_a=7
    exp_q.push_back({4'b1100, 8'h80});  // wb 7
    exp_q.push_back({4'b1000, 8'h00});  // idle
    for (int step = 0; step < 5; step++) begin
      logic [11:0] exp;
      logic [11:0] act;
      case (step)
        0: drive_small(1'b1, 3'd3, 1'b0, 3'd0, 3'd3);
        1: drive_small(1'b0, 3'd0, 1'b1, 3'd3, 3'd3);
        2: drive_small(1'b1, 3'd7, 1'b0, 3'd0, 3'd7);
        3: drive_small(1'b0, 3'd0, 1'b1, 3'd7, 3'd7);
        default: drive_small(1'b0, 3'd0, 1'b0, 3'd0, 3'd7);
      endcase
      @(negedge clk);
      exp = exp_q.pop_front();
      act = {s_issue_ready, s_busy_a, s_busy_b, s_wb_underflow, s_pending_vec};
      check($sformatf("small_step%0d", step), {24'h0, act}, {24'h0, exp});
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
- Parametrised register-pending tracker for the 5-stage pipeline.
- Decodes the issuing instruction's destination register into a per-register pending counter and increments it.
- Decodes the writeback register and decrements that counter.
- Reports whether either source register of the instruction in decode still has a write in flight.
- Generalises the fixed 3-to-8 decode tree: any address width, hardwired-zero register masking, and state per decoded output.

Parameters:
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W tracked registers.
- CNT_W, 2, per-register pending counter width; max outstanding writes per register = 2**CNT_W-1.
- ZERO_EN, 1, when 1, register ZERO_REG is never tracked (reads as not busy, issue/writeback ignored).
- ZERO_REG, 31, index of the hardwired-zero register (XZR).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- flush  in  1  clear all pending state (pipeline squash).
- issue_en  in  1  instruction with a register write is issuing this cycle.
- issue_rd  in  ADDR_W  destination register of the issuing instruction.
- issue_ready  out  1  issue will be accepted (destination counter not saturated).
- wb_en  in  1  writeback completing this cycle.
- wb_rd  in  ADDR_W  writeback destination register.
- rs_a  in  ADDR_W  source register A query.
- rs_b  in  ADDR_W  source register B query.
- busy_a  out  1  rs_a has at least one pending write.
- busy_b  out  1  rs_b has at least one pending write.
- pending_vec  out  NUM_REGS  bit i = counter i nonzero.
- wb_underflow  out  1  sticky error: writeback arrived for a register with count 0.

Behaviour:
- State: NUM_REGS counters, CNT_W bits each, plus the sticky wb_underflow flag. All updates on the rising edge of clk.
- reset (priority 1): all counters = 0, wb_underflow = 0. After reset, pending_vec = 0, busy_a = busy_b = 0, issue_ready = 1.
- flush (priority 2, only when reset low): all counters = 0. wb_underflow is held. Issue and writeback in the same cycle are discarded.
- Decode: issue_rd and wb_rd each decode to a one-hot NUM_REGS vector, gated by issue_acc and wb_en respectively.
- issue_acc = issue_en & issue_ready & !(ZERO_EN & issue_rd==ZERO_REG).
- issue_ready (combinational) = counter[issue_rd] != all-ones, OR (wb_en & wb_rd==issue_rd & counter nonzero).
  - A simultaneous retire frees the slot.
  - issue_ready is 1 for ZERO_REG when ZERO_EN=1.
- Per-register update when neither reset nor flush:
  - inc only: +1.
  - dec only (count>0): -1.
  - inc and dec same cycle: unchanged.
  - Counters never wrap; saturation is prevented by issue_ready.
- Writeback to a register with count 0 (and not ZERO_REG with ZERO_EN=1): no counter change; wb_underflow set on the next edge and held until reset.
  - If an issue to the same register is accepted in the same cycle, this still counts as underflow. The counter becomes 1.
- busy_a/busy_b are combinational reads of the registered counters. Latency: issue at edge N makes busy visible from cycle N+1. No same-cycle bypass of issue or writeback into busy.
- busy_x = 0 whenever ZERO_EN=1 and rs_x==ZERO_REG.
- pending_vec = OR-reduce of each counter, registered state only. Bit ZERO_REG is always 0 when ZERO_EN=1.
- Out-of-range addresses are impossible (NUM_REGS = 2**ADDR_W).

Test Plan:
- Reset, then issue_en=1, issue_rd=3, one cycle -> pending_vec=0x00000008; rs_a=3 gives busy_a=1; then wb_en=1, wb_rd=3 -> next cycle pending_vec=0, busy_a=0.
- Issue rd=7 three consecutive cycles (CNT_W=2) -> issue_ready=0 on the 4th attempt with issue_rd=7, counter stays 3. Then issue rd=7 with wb rd=7 in the same cycle -> issue_ready=1, counter remains 3.
- Issue rd=31 with ZERO_EN=1 -> pending_vec unchanged (0); rs_b=31 gives busy_b=0. wb rd=31 with count 0 -> wb_underflow stays 0.
- Issue rd=5 and rd=9, then wb rd=12 (count 0) -> wb_underflow=1 next cycle; counters 5 and 9 unchanged (pending_vec=0x00000220). Flush -> pending_vec=0, wb_underflow still 1. Reset -> wb_underflow=0.
- Issue rd=2 asserted in the same cycle as flush -> pending_vec=0 after the edge. Issue rd=2 in the same cycle as reset -> all outputs at reset values.
- Re-run the first scenario with ADDR_W=3, ZERO_EN=0 -> pending_vec 8 bits wide; register 7 is tracked normally (issue rd=7 gives pending_vec=0x80).
